uart_fifo: RTL and testbench

Synchronous single-clock FIFO used in the UART datapath to buffer TX and RX bytes between the bus-side register interface and the serialiser/deserialiser. It provides registered read data, full/empty flags, an occupancy count and a programmable level-threshold flag for interrupt generation.

---
 rtl/uart_fifo_pkg.sv | 25 ++
 rtl/uart_fifo_if.sv | 42 ++++
 rtl/uart_fifo_mem.sv | 45 ++++
 rtl/uart_fifo.sv | 100 ++++++++++
 tb/tb_uart_fifo.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/uart_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_fifo_pkg
// Shared definitions for the UART byte FIFO:
//   - default data width and depth of the UART datapath buffers
//   - fifo_op_e : which of push/pop an edge actually accepts
//   - decode_op : folds the accepted push/pop strobes into fifo_op_e
// ---------------------------------------------------------------------------
package uart_fifo_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  // Operation accepted on a clock edge; encoding is {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_fifo_if
// Bus-side bundle of the UART FIFO.
//   write_en/data_in   : push request and word
//   read_en            : pop request
//   data_out           : word from the most recent accepted pop (registered)
//   empty/full/level   : occupancy status
//   threshold          : level comparison value
//   threshold_reached  : level >= threshold
// master = the agent driving requests, slave = the FIFO itself.
// ---------------------------------------------------------------------------
interface uart_fifo_if
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH = UART_FIFO_DEPTH
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic             write_en;
  logic             read_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic [LW-1:0]    level;
  logic [LW-1:0]    threshold;
  logic             threshold_reached;

  modport master (
    output write_en, read_en, data_in, threshold,
    input  data_out, empty, full, level, threshold_reached
  );

  modport slave (
    input  write_en, read_en, data_in, threshold,
    output data_out, empty, full, level, threshold_reached
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// Simple dual-port storage for the UART FIFO: one write port and one
// registered read port, written so the array can map onto distributed or
// block RAM.
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr       : read request; rdata loads mem[raddr] on the edge
//   rdata          : registered read data, holds when re is low
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Array write; contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port. The controller never reads the slot being written
  // on the same edge (pop is blocked when empty), so no bypass is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Single-clock FIFO buffering UART TX/RX bytes between the register
// interface and the serialiser/deserialiser.
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset; empties the FIFO, clears data_out
//   bus    : uart_fifo_if.slave (requests in, data/status out)
// Push and pop are each judged against the flags before the edge, so a
// simultaneous request on an empty FIFO only pushes (no fall-through) and on
// a full FIFO only pops (the write is dropped).
// ---------------------------------------------------------------------------
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1'b1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_nxt_s;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  fifo_op_e         op_s;
  logic [WIDTH-1:0] rdata_s;

  // Flag decode of the current level and acceptance of the requests.
  always_comb begin
    empty_s = (level_r == {LW{1'b0}});
    full_s  = (level_r == LVL_MAX);
    push_s  = bus.write_en && !full_s;
    pop_s   = bus.read_en && !empty_s;
    op_s    = decode_op(push_s, pop_s);
  end

  // Next occupancy: a push and a pop on the same edge cancel out.
  always_comb begin
    level_nxt_s = level_r;
    case (op_s)
      OP_PUSH: level_nxt_s = level_r + LVL_ONE;
      OP_POP:  level_nxt_s = level_r - LVL_ONE;
      OP_BOTH: level_nxt_s = level_r;
      OP_IDLE: level_nxt_s = level_r;
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointer and level registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
    end
  end

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (bus.data_in),
    .re    (pop_s),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  assign bus.data_out          = rdata_s;
  assign bus.level             = level_r;
  assign bus.empty             = empty_s;
  assign bus.full              = full_s;
  assign bus.threshold_reached = (level_r >= bus.threshold);

endmodule

// File: tb/tb_uart_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo
// Directed bench for uart_fifo (WIDTH=8, DEPTH=16). Inputs are applied
// before a rising edge and outputs are sampled 1 ns after it.
// ---------------------------------------------------------------------------
module tb_uart_fifo;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  uart_fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();

  uart_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given requests, then sample point.
  task automatic cyc(input logic we, input logic re, input logic [7:0] din);
    bus.write_en = we;
    bus.read_en  = re;
    bus.data_in  = din;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.write_en  = 1'b0;
    bus.read_en   = 1'b0;
    bus.data_in   = 8'h00;
    bus.threshold = 5'd1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_dout", 32'(bus.data_out), 32'h00);
    chk("rst_thr1", 32'(bus.threshold_reached), 32'd0);
    bus.threshold = 5'd0;
    #1;
    chk("rst_thr0", 32'(bus.threshold_reached), 32'd1);
    bus.threshold = 5'd1;
    @(negedge clk);
    rst_n = 1'b1;

    // Single push / pop
    cyc(1'b1, 1'b0, 8'hA5);
    chk("one_level", 32'(bus.level), 32'd1);
    chk("one_empty", 32'(bus.empty), 32'd0);
    chk("one_thr", 32'(bus.threshold_reached), 32'd1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("one_dout", 32'(bus.data_out), 32'hA5);
    chk("one_empty2", 32'(bus.empty), 32'd1);
    chk("one_level2", 32'(bus.level), 32'd0);

    // Fill, overflow push, drain in order
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_level", 32'(bus.level), 32'd16);
    cyc(1'b1, 1'b0, 8'hFF);
    chk("ovf_level", 32'(bus.level), 32'd16);
    chk("ovf_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("drain_dout", 32'(bus.data_out), 32'(i));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_level", 32'(bus.level), 32'd0);

    // Underflow pop keeps data_out
    cyc(1'b0, 1'b1, 8'h00);
    chk("udf_dout", 32'(bus.data_out), 32'h0F);
    chk("udf_level", 32'(bus.level), 32'd0);

    // Threshold at 4
    bus.threshold = 5'd4;
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    cyc(1'b1, 1'b0, 8'h03);
    chk("thr_below", 32'(bus.threshold_reached), 32'd0);
    cyc(1'b1, 1'b0, 8'hAA);
    chk("thr_at", 32'(bus.threshold_reached), 32'd1);
    chk("thr_level", 32'(bus.level), 32'd4);
    cyc(1'b0, 1'b1, 8'h00);
    chk("thr_d1", 32'(bus.data_out), 32'h01);
    chk("thr_drop", 32'(bus.threshold_reached), 32'd0);
    cyc(1'b0, 1'b1, 8'h00);
    chk("thr_d2", 32'(bus.data_out), 32'h02);
    cyc(1'b0, 1'b1, 8'h00);
    chk("thr_d3", 32'(bus.data_out), 32'h03);
    cyc(1'b0, 1'b1, 8'h00);
    chk("thr_d4", 32'(bus.data_out), 32'hAA);
    chk("thr_empty", 32'(bus.empty), 32'd1);
    chk("thr_off", 32'(bus.threshold_reached), 32'd0);
    bus.threshold = 5'd1;

    // Interleaved push/pop, pointers wrap twice
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      cyc(1'b0, 1'b1, 8'h00);
      chk("ilv_dout", 32'(bus.data_out), 32'(i));
      chk("ilv_level", 32'(bus.level), 32'd0);
    end
    chk("ilv_empty", 32'(bus.empty), 32'd1);

    // Simultaneous read+write at empty: push only, no fall-through
    cyc(1'b1, 1'b1, 8'h55);
    chk("rw_empty_level", 32'(bus.level), 32'd1);
    chk("rw_empty_dout", 32'(bus.data_out), 32'h1F);
    // At level 1: both happen
    cyc(1'b1, 1'b1, 8'h66);
    chk("rw_one_level", 32'(bus.level), 32'd1);
    chk("rw_one_dout", 32'(bus.data_out), 32'h55);
    // Fill to full then read+write: write dropped
    for (int k = 0; k < 15; k++) cyc(1'b1, 1'b0, 8'(8'h70 + k));
    chk("rw_pre_full", 32'(bus.full), 32'd1);
    cyc(1'b1, 1'b1, 8'hEE);
    chk("rw_full_level", 32'(bus.level), 32'd15);
    chk("rw_full_dout", 32'(bus.data_out), 32'h66);
    chk("rw_full_flag", 32'(bus.full), 32'd0);
    for (int k = 0; k < 15; k++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("rw_drain_dout", 32'(bus.data_out), 32'(8'h70 + k));
    end
    chk("rw_drain_empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset mid-operation
    cyc(1'b1, 1'b0, 8'h3C);
    cyc(1'b1, 1'b0, 8'hC3);
    cyc(1'b0, 1'b1, 8'h00);
    chk("mid_pre_dout", 32'(bus.data_out), 32'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_level", 32'(bus.level), 32'd0);
    chk("mid_dout", 32'(bus.data_out), 32'h00);
    chk("mid_empty", 32'(bus.empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_pop_dout", 32'(bus.data_out), 32'h00);
    chk("post_pop_level", 32'(bus.level), 32'd0);
    cyc(1'b1, 1'b0, 8'h5A);
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_dout", 32'(bus.data_out), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
